// File: rtl/risc8_pkg.sv
// RISC-8 shared definitions: opcodes, ALU operations, instruction field layout.
// No logic; constants and one sign-extension helper only.
// Imported by the decode stage, its interface and the testbench.
package risc8_pkg;

  localparam int INSTR_BITS = 16;
  localparam int DATA_BITS  = 8;
  localparam int NUM_REGS   = 8;
  localparam int REG_AW     = 3;

  // Opcodes (instr[15:12]); 10..15 are undefined
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LD   = 4'd7;
  localparam logic [3:0] OP_ST   = 4'd8;
  localparam logic [3:0] OP_MOVI = 4'd9;

  // ALU operations handed to EX
  localparam logic [2:0] ALU_ADD     = 3'd0;
  localparam logic [2:0] ALU_SUB     = 3'd1;
  localparam logic [2:0] ALU_AND     = 3'd2;
  localparam logic [2:0] ALU_OR      = 3'd3;
  localparam logic [2:0] ALU_XOR     = 3'd4;
  localparam logic [2:0] ALU_ADDIMM  = 3'd5;
  localparam logic [2:0] ALU_PASSIMM = 3'd6;

  // Instruction field bit positions
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int RS1_HI  = 8;
  localparam int RS1_LO  = 6;
  localparam int RS2_HI  = 5;
  localparam int RS2_LO  = 3;
  localparam int IMM6_HI = 5;
  localparam int IMM8_HI = 7;

  localparam logic [INSTR_BITS-1:0] NOP_INSTR = 16'h0000;

  // Sign-extend the 6-bit immediate to data width
  function automatic logic [DATA_BITS-1:0] sext6(input logic [5:0] v);
    return {{(DATA_BITS-6){v[5]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch input, EX hazard feedback, write-back port, decoded outputs.
// Pure wiring, no latency.
// No handshake; stall_out is the only flow-control signal (towards fetch).
interface id_stage_if;
  import risc8_pkg::*;

  logic [INSTR_BITS-1:0] instr_in;
  logic                  instr_valid_in;
  logic                  flush;
  logic                  mem_read_ex;
  logic [REG_AW-1:0]     rd_ex;
  logic                  wb_reg_write;
  logic [REG_AW-1:0]     wb_rd;
  logic [DATA_BITS-1:0]  wb_data;

  logic [DATA_BITS-1:0]  read_data1_out;
  logic [DATA_BITS-1:0]  read_data2_out;
  logic [DATA_BITS-1:0]  immediate_out;
  logic [2:0]            alu_op_out;
  logic                  mem_read_out;
  logic                  mem_write_out;
  logic                  reg_write_out;
  logic                  mem_to_reg_out;
  logic [REG_AW-1:0]     rd_out;
  logic                  stall_out;
  logic                  illegal_out;

  // Pipeline side that feeds the decode stage and consumes its results
  modport master (
    output instr_in, instr_valid_in, flush, mem_read_ex, rd_ex,
           wb_reg_write, wb_rd, wb_data,
    input  read_data1_out, read_data2_out, immediate_out, alu_op_out,
           mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out,
           rd_out, stall_out, illegal_out
  );

  // The decode stage itself
  modport slave (
    input  instr_in, instr_valid_in, flush, mem_read_ex, rd_ex,
           wb_reg_write, wb_rd, wb_data,
    output read_data1_out, read_data2_out, immediate_out, alu_op_out,
           mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out,
           rd_out, stall_out, illegal_out
  );

endinterface

// File: rtl/register_file.sv
// 8x8 register file: two combinational read ports, one write port, write-first bypass.
// Reads are zero-latency; writes land at the clock edge, visible same cycle via bypass.
// No backpressure; every write request is accepted.
module register_file #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Storage: cleared asynchronously, written on the edge when enabled (r0 included)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: a same-cycle write to the read address wins over the stored value
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
  end

endmodule

// File: rtl/id_stage.sv
// RISC-8 decode stage: IF/ID latch, register file, decoder, load-use hazard detect.
// One cycle: instruction latched at edge N is decoded during cycle N+1.
// On load-use, stall_out holds fetch and the latch, and controls are zeroed (bubble).
module id_stage
  import risc8_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 8,
  parameter int NREGS   = 8
) (
  input logic      clk,
  input logic      reset,
  id_stage_if.slave bus
);

  logic [INSTR_W-1:0] ifid_q, ifid_d;

  logic [3:0]        opcode;
  logic [REG_AW-1:0] rd_f, rs1_f, rs2_f, rb_addr;
  logic [5:0]        imm6_f;
  logic [7:0]        imm8_f;

  logic              use_rs1, use_rs2, use_rd;
  logic              stall;
  logic [2:0]        dec_alu;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_mr, dec_mw, dec_rw, dec_m2r, dec_ill;
  logic [DATA_W-1:0] rdata1, rdata2;

  assign opcode = ifid_q[OPC_HI:OPC_LO];
  assign rd_f   = ifid_q[RD_HI:RD_LO];
  assign rs1_f  = ifid_q[RS1_HI:RS1_LO];
  assign rs2_f  = ifid_q[RS2_HI:RS2_LO];
  assign imm6_f = ifid_q[IMM6_HI:0];
  assign imm8_f = ifid_q[IMM8_HI:0];

  // Port B reads the store-data register for ST, rs2 otherwise
  assign rb_addr = (opcode == OP_ST) ? rd_f : rs2_f;

  // IF/ID next value: flush beats stall, stall holds, otherwise take fetch or a NOP
  always_comb begin
    ifid_d = NOP_INSTR;
    if (bus.flush)               ifid_d = NOP_INSTR;
    else if (stall)              ifid_d = ifid_q;
    else if (bus.instr_valid_in) ifid_d = bus.instr_in;
  end

  // IF/ID instruction latch, NOP on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ifid_q <= NOP_INSTR;
    else       ifid_q <= ifid_d;
  end

  // Instruction decoder: controls, ALU op, immediate and which sources are really read
  always_comb begin
    dec_alu = ALU_ADD;
    dec_imm = '0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_rw  = 1'b0;
    dec_m2r = 1'b0;
    dec_ill = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        case (opcode)
          OP_SUB:  dec_alu = ALU_SUB;
          OP_AND:  dec_alu = ALU_AND;
          OP_OR:   dec_alu = ALU_OR;
          OP_XOR:  dec_alu = ALU_XOR;
          default: dec_alu = ALU_ADD;
        endcase
        dec_rw  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ADDI: begin
        dec_alu = ALU_ADDIMM;
        dec_imm = sext6(imm6_f);
        dec_rw  = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_LD: begin
        dec_alu = ALU_ADDIMM;
        dec_imm = sext6(imm6_f);
        dec_mr  = 1'b1;
        dec_m2r = 1'b1;
        dec_rw  = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_ST: begin
        dec_alu = ALU_ADDIMM;
        dec_imm = sext6(imm6_f);
        dec_mw  = 1'b1;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_MOVI: begin
        dec_alu = ALU_PASSIMM;
        dec_imm = imm8_f;
        dec_rw  = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Load-use hazard: only sources the opcode actually reads can match the load target
  always_comb begin
    stall = bus.mem_read_ex &&
            ((use_rs1 && (rs1_f == bus.rd_ex)) ||
             (use_rs2 && (rs2_f == bus.rd_ex)) ||
             (use_rd  && (rd_f  == bus.rd_ex)));
  end

  register_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (REG_AW)
  ) u_rf (
    .clk      (clk),
    .rst      (reset),
    .we_i     (bus.wb_reg_write),
    .waddr_i  (bus.wb_rd),
    .wdata_i  (bus.wb_data),
    .raddr1_i (rs1_f),
    .raddr2_i (rb_addr),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  // Outputs; a stalled cycle becomes a bubble by zeroing ALU op and controls
  assign bus.read_data1_out = rdata1;
  assign bus.read_data2_out = rdata2;
  assign bus.immediate_out  = dec_imm;
  assign bus.alu_op_out     = stall ? ALU_ADD : dec_alu;
  assign bus.mem_read_out   = dec_mr  && !stall;
  assign bus.mem_write_out  = dec_mw  && !stall;
  assign bus.reg_write_out  = dec_rw  && !stall;
  assign bus.mem_to_reg_out = dec_m2r && !stall;
  assign bus.rd_out         = rd_f;
  assign bus.stall_out      = stall;
  assign bus.illegal_out    = dec_ill;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the RISC-8 pipeline. It sits between instruction fetch and the ID/EX pipeline register.
- It holds the IF/ID instruction latch, the 8x8 register file and the instruction decoder, and it detects load-use hazards.
- Its decoded outputs drive the ID/EX register inputs one-to-one.
- It stalls fetch, and injects a bubble, when an instruction depends on a load still in EX.

Parameters:
- INSTR_W, 16, instruction width.
- DATA_W, 8, register and data width.
- NREGS, 8, register count; register address width is 3.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- instr_in  input  16  instruction from fetch.
- instr_valid_in  input  1  instr_in is valid this cycle.
- flush  input  1  discard the IF/ID contents.
- mem_read_ex  input  1  the instruction now in EX is a load (ID/EX mem_read_out).
- rd_ex  input  3  destination of the instruction in EX (ID/EX rd_out).
- wb_reg_write  input  1  write-back enable.
- wb_rd  input  3  write-back register.
- wb_data  input  8  write-back data.
- read_data1_out  output  8  operand A, value of reg[rs1].
- read_data2_out  output  8  operand B, reg[rs2], or store data reg[rd] for ST.
- immediate_out  output  8  extended immediate.
- alu_op_out  output  3  ALU operation.
- mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out  output  1 each  control signals.
- rd_out  output  3  destination field.
- stall_out  output  1  hold PC and fetch.
- illegal_out  output  1  the latched opcode is undefined.

Behaviour:
- Instruction format: opcode [15:12], rd [11:9], rs1 [8:6], rs2 [5:3], imm6 [5:0] (sign-extended to 8 bits), imm8 [7:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: R-type, use rs1 and rs2.
  - 6 ADDI: uses rs1, imm6.
  - 7 LD: rd <- mem[rs1+imm6].
  - 8 ST: mem[rs1+imm6] <- reg[rd]; uses rs1 and rd.
  - 9 MOVI: rd <- imm8; uses no sources.
  - 10-15: illegal.
- alu_op encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADDIMM (A+imm), 6 PASSIMM, 7 reserved.
  - LD and ST use ADDIMM.
  - MOVI uses PASSIMM with immediate_out = imm8.
  - R-type instructions drive immediate_out = 0.
- Control signals:
  - LD: mem_read=1, mem_to_reg=1, reg_write=1.
  - ST: mem_write=1, reg_write=0; rd_out still carries the rd field.
  - R-type, ADDI, MOVI: reg_write=1.
  - NOP and illegal: all controls 0, alu_op 0, immediates 0. Illegal also sets illegal_out=1.
- IF/ID latch: 16-bit instruction register. Update priority at each clock edge:
  1. reset: load NOP, asynchronously.
  2. flush: load NOP.
  3. stall_out=1: hold the current instruction.
  4. instr_valid_in=1: load instr_in.
  5. Otherwise: load NOP.
- Latency: an instruction latched at edge N is decoded combinationally during cycle N+1 and captured by ID/EX at edge N+1.
- Register file:
  - 8 entries, all writable (r0 is not hardwired).
  - Written at the clock edge when wb_reg_write=1.
  - Two combinational read ports with write-first bypass: if wb_reg_write=1 and wb_rd equals the read address, the port returns wb_data in that same cycle.
  - Asynchronous reset clears every entry to 0.
- Load-use hazard: stall_out = mem_read_ex AND (rd_ex equals any source register actually used by the latched instruction).
  - Sources that the opcode does not use never cause a stall.
  - NOP, MOVI and illegal opcodes never stall.
- Bubble while stalled: all control outputs and alu_op_out are forced to 0. The data outputs may carry any value. The IF/ID latch holds, so the instruction is re-decoded in the next cycle, when the load has moved on to MEM.
- flush and stall in the same cycle: flush wins at the edge. stall_out is still driven combinationally for that cycle.
- Outputs during and just after reset: the IF/ID latch holds NOP, so every output is 0 and stall_out=0.
- Reset mid-operation: the latch and register file clear immediately, without waiting for a clock edge.

Decomposition:
- Shared package risc8_pkg holds:
  - opcode constants (OP_NOP .. OP_MOVI);
  - alu_op constants;
  - instruction field bit positions;
  - the NOP encoding 16'h0000.
- Sub-module register_file: 8x8, two read ports, one write port, write-first bypass, asynchronous reset.
- The decoder and the hazard logic stay inline in id_stage.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset mid-cycle, then release it.
  - Required: all outputs 0 immediately, all registers read 0, stall_out=0.
- MOVI then ADD:
  - Stimulus: WB writes r1=8'h05 and r2=8'h03. Then feed ADD r3,r1,r2 (16'h1650).
  - Required: next cycle read_data1_out=05, read_data2_out=03, alu_op_out=0, reg_write_out=1, rd_out=3.
- Write-first bypass:
  - Stimulus: wb_reg_write=1, wb_rd=2, wb_data=8'hAA, in the same cycle that the latched instruction reads r2.
  - Required: read_data2_out=AA.
- Load-use stall:
  - Stimulus: mem_read_ex=1, rd_ex=1, latched ADD uses r1.
  - Required: stall_out=1 and all controls 0; latch holds for one cycle. When mem_read_ex drops, the ADD is decoded normally.
  - Negative case: the same setup with MOVI latched gives stall_out=0.
- ST and ADDI decode:
  - Stimulus: ST with rd=4, rs1=2, imm6=6'h3F.
  - Required: immediate_out=8'hFF, alu_op_out=5, mem_write_out=1, reg_write_out=0, read_data2_out=reg[4].
- Flush and illegal opcode:
  - Stimulus: flush=1 while stalled.
  - Required: the latch becomes NOP at the edge.
  - Stimulus: opcode 4'hF.
  - Required: illegal_out=1 and all controls 0.
